ram_burst_reader: RTL
=====================

// Module: ram_burst_reader
// PURPOSE
//  Parametrised multi-channel RAM read sequencer; successor to the fixed 10-channel/8-word reader.
//  On a start pulse, reads BURST_LEN words from each enabled channel RAM, in ascending channel order.
//  Streams them on a valid/ready output with channel tag and burst/frame markers, toward the PS/DDR writer.
//  Adds over the previous generation: channel mask, read address output, programmable RAM latency,
//  output backpressure with credit-limited issue, busy/done status.
// PARAMETERS
//  NUM_CH     10  number of channel RAMs (>=1)
//  DATA_W     32  RAM word width
//  BURST_LEN  8   words read per enabled channel (>=1)
//  RAM_LAT    2   cycles from ram_rd_en high to ram_rd_data valid (>=1)
//  Derived: AW = max(1,clog2(BURST_LEN)), CW = max(1,clog2(NUM_CH)), DEPTH = RAM_LAT+2
// PORTS
//  clk_ps       in   1             sole clock, all logic on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  start        in   1             one-cycle frame request (role of data_ddr_flag)
//  ch_mask      in   NUM_CH        channel enable bits, sampled on accepted start
//  busy         out  1             high from accepted start through the cycle of done
//  done         out  1             one-cycle pulse when the frame is fully delivered
//  ram_rd_en    out  NUM_CH        one-hot read enable, bit = current channel
//  ram_rd_addr  out  AW            word address within burst, shared by all RAMs
//  ram_rd_data  in   NUM_CH*DATA_W flat RAM outputs; channel k = bits [k*DATA_W +: DATA_W]
//  m_valid      out  1             output word valid
//  m_ready      in   1             downstream accept; transfer when m_valid & m_ready
//  m_data       out  DATA_W        output word
//  m_ch         out  CW            channel index of m_data
//  m_sop        out  1             first word of a channel burst
//  m_eop        out  1             last word of a channel burst
//  m_last       out  1             last word of the frame
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; counters, issue pipeline and output FIFO cleared.
//    Reset mid-frame aborts immediately; no done is emitted.
//  - FSM IDLE: start & (ch_mask != 0) -> ISSUE. Latch mask; ch = lowest set bit; addr = 0.
//    start & (ch_mask == 0) -> done=1 next cycle, busy high that cycle only, no reads.
//  - FSM ISSUE: a read issues in a cycle when (outstanding + fifo_count) < DEPTH.
//    outstanding = reads issued but data not yet captured.
//    Issue: ram_rd_en = onehot(ch), ram_rd_addr = addr.
//    No issue: ram_rd_en = 0, ram_rd_addr holds.
//    After issue: addr+1; at addr==BURST_LEN-1, addr->0 and ch -> next set mask bit.
//    No higher bit set -> DRAIN.
//  - FSM DRAIN: wait for outstanding==0 and FIFO empty with final word transferred.
//    Then done=1 for one cycle -> IDLE.
//  - start while busy is ignored. ch_mask changes after acceptance have no effect.
//  - Issue pipeline: {ch, sop, eop, last} tag delayed RAM_LAT cycles alongside each read.
//    On tag valid, capture ram_rd_data slice [ch] and push into FIFO (depth DEPTH).
//    Credit rule guarantees the FIFO never overflows; push and pop in the same cycle is legal.
//  - Output: m_valid = FIFO non-empty; head word/tags held stable while m_valid & !m_ready.
//    Minimum latency: start at cycle 0 -> first ram_rd_en at cycle 1 -> m_valid at cycle 1+RAM_LAT+1.
//    With m_ready=1 continuously: one word per cycle, no bubbles across channel boundaries.
//  - Markers: m_sop at addr 0, m_eop at addr BURST_LEN-1, m_last on the final word of the last enabled channel.
//    BURST_LEN==1: sop and eop both set on each word.
//  - Frame totals: words = BURST_LEN * popcount(mask); masked channels produce no reads and no output.
// TESTING
//  1 Defaults, mask=10'h3FF, m_ready=1: 80 words, m_ch 0..9, 8 per ch.
//    m_data = ch*256+addr pattern; first m_valid 4 cycles after start; done 1 cycle after last transfer.
//  2 mask=10'b1000100001: only ch 0,5,9 read; 24 words.
//    ram_rd_en never sets bits 1-4,6-8; m_last on ch9 addr7.
//  3 Backpressure: m_ready random 50%, then held low 20 cycles.
//    At most DEPTH words in flight; no loss/duplication; data/tags stable while stalled.
//  4 mask=0: done pulse 1 cycle after start; m_valid and ram_rd_en stay 0.
//    Second start during a busy frame is ignored (word count unchanged).
//  5 rst_n low mid-burst (ch3 addr4): all outputs 0 asynchronously, no done.
//    Next start runs a clean full frame.
//  6 Params NUM_CH=3, BURST_LEN=1, RAM_LAT=4: 3 words, each with sop=eop=1; ordering and latency per rules.

Source files
------------

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Multi-channel RAM read sequencer. A start pulse reads BURST_LEN words from
// every enabled channel RAM in ascending channel order. The words go out on a
// valid/ready stream tagged with their channel and with burst/frame markers.
//
// Ports
//   clk_ps       sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle frame request, ignored while busy
//   ch_mask      channel enable bits, captured when start is accepted
//   busy         high from the accepted start through the done cycle
//   done         one-cycle pulse once the last word has been delivered
//   ram_rd_en    one-hot read enable, bit = channel being read
//   ram_rd_addr  word address within the burst, shared by all RAMs
//   ram_rd_data  flat RAM outputs, channel k at [k*DATA_W +: DATA_W]
//   m_valid      output word valid
//   m_ready      downstream accept
//   m_data       output word
//   m_ch         channel index of m_data
//   m_sop        first word of a channel burst
//   m_eop        last word of a channel burst
//   m_last       last word of the frame
module ram_burst_reader #(
    parameter int NUM_CH    = 10,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int RAM_LAT   = 2,
    localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_ps,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH-1:0]        ram_rd_en,
    output logic [AW-1:0]            ram_rd_addr,
    input  logic [NUM_CH*DATA_W-1:0] ram_rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [CW-1:0]            m_ch,
    output logic                     m_sop,
    output logic                     m_eop,
    output logic                     m_last
);

    localparam int DEPTH = RAM_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          sop;
        logic          eop;
        logic          last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } entry_t;

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [CW-1:0]     ch;
    logic [AW-1:0]     addr;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [RAM_LAT:0]  pipe_vld;
    tag_t              pipe_tag [RAM_LAT+1];
    entry_t            fifo_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    entry_t            head;

    logic [NUM_CH-1:0] sel_mask;
    logic [CW-1:0]     sel_ch;
    logic [AW-1:0]     sel_addr;
    logic [CW:0]       first_hit;
    logic [CW:0]       next_hit;
    logic              tag_sop;
    logic              tag_eop;
    logic              tag_last;
    logic              credit_ok;
    logic              do_issue;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] cap_data;

    // Lowest set bit of m strictly above index 'from'; MSB of result = found.
    function automatic logic [CW:0] find_above(input logic [NUM_CH-1:0] m, input int from);
        logic [CW:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > from && m[i]) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The read position about to be issued: in IDLE it is the first enabled
    // channel of the incoming mask, so the first read goes out the cycle
    // after start; otherwise it is the running channel/address.
    // The credit check lets the head word popped this cycle hand its slot
    // straight to a new read, which keeps the stream free of bubbles.
    always_comb begin
        first_hit = find_above(ch_mask, -1);
        if (state == IDLE) begin
            sel_mask = ch_mask;
            sel_ch   = first_hit[CW-1:0];
            sel_addr = '0;
        end else begin
            sel_mask = mask_q;
            sel_ch   = ch;
            sel_addr = addr;
        end
        next_hit  = find_above(sel_mask, int'(sel_ch));
        tag_sop   = (sel_addr == '0);
        tag_eop   = (sel_addr == AW'(BURST_LEN - 1));
        tag_last  = tag_eop & ~next_hit[CW];
        pop       = m_valid & m_ready;
        push      = pipe_vld[RAM_LAT];
        credit_ok = (int'(outstanding) + int'(fifo_count)) < (DEPTH + int'(pop));
        do_issue  = ((state == IDLE) && start && first_hit[CW]) ||
                    ((state == ISSUE) && credit_ok);
        cap_data  = ram_rd_data[pipe_tag[RAM_LAT].ch * DATA_W +: DATA_W];
    end

    // Frame sequencer. FINISH is the single done cycle, during which busy is
    // still high, so a start arriving alongside done is ignored.
    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            ch          <= '0;
            addr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_en   <= '0;
            ram_rd_addr <= '0;
        end else begin
            done <= 1'b0;
            if (do_issue) begin
                ram_rd_en   <= NUM_CH'(1) << sel_ch;
                ram_rd_addr <= sel_addr;
                if (tag_eop) begin
                    addr <= '0;
                    ch   <= next_hit[CW-1:0];
                end else begin
                    addr <= sel_addr + 1'b1;
                    ch   <= sel_ch;
                end
            end else begin
                ram_rd_en <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (first_hit[CW]) begin
                            mask_q <= ch_mask;
                            state  <= tag_last ? DRAIN : ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                ISSUE: begin
                    if (do_issue && tag_last) state <= DRAIN;
                end
                DRAIN: begin
                    // Done lands the cycle after the final word is accepted.
                    if (outstanding == '0 &&
                        (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline: stage 0 lines up with ram_rd_en, stage RAM_LAT with the
    // cycle the RAM data is valid. Outstanding counts reads not yet captured.
    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld    <= '0;
            outstanding <= '0;
            for (int i = 0; i <= RAM_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= do_issue;
            pipe_tag[0] <= {sel_ch, tag_sop, tag_eop, tag_last};
            for (int i = 1; i <= RAM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            outstanding <= outstanding + CNT_W'(do_issue) - CNT_W'(push);
        end
    end

    // Output FIFO. Storage is cleared on reset so every output reads zero.
    always_ff @(posedge clk_ps or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cap_data, pipe_tag[RAM_LAT]};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head    = fifo_mem[rd_ptr];
    assign m_valid = (fifo_count != '0);
    assign m_data  = head.data;
    assign m_ch    = head.tag.ch;
    assign m_sop   = head.tag.sop;
    assign m_eop   = head.tag.eop;
    assign m_last  = head.tag.last;

endmodule
